usb_tx: RTL and testbench
=========================

USB_TX -- requirements
Module: usb_tx

Interface
REQ-001 clk  input  1  system clock, 48 MHz; one USB full-speed bit cell = 4 clk.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 TX_packet  input  3  packet request: 0 none, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL, 6/7 invalid.
REQ-004 TX_packet_data  input  8  payload byte from TX FIFO, valid the cycle after get_TX_packet_data.
REQ-005 buffer_occupancy  input  7  payload byte count in FIFO, 0-64.
REQ-006 get_TX_packet_data  output  1  one-clk FIFO pop strobe.
REQ-007 dp_out, dm_out  output  1 each  bus drive; idle J = (1,0).
REQ-008 TX_transfer_active  output  1  high while a packet is on the bus.
REQ-009 TX_error  output  1  one-clk pulse on rejected request.

Function
REQ-010 FSM states: IDLE, SYNC, PID, LOAD, DATA, CRC_LO, CRC_HI, EOP_SE0, EOP_J; SHALL follow this order, skipping LOAD/DATA/CRC states for ACK/NAK/STALL.
REQ-011 In IDLE, TX_packet 1-5 is accepted on that clk; TX_packet and buffer_occupancy SHALL be latched; later changes are ignored until return to IDLE.
REQ-012 TX_packet 6/7 in IDLE SHALL pulse TX_error for 1 clk, with no bus activity.
REQ-013 The first SYNC bit SHALL appear on dp_out/dm_out 1 clk after acceptance; every bit cell SHALL last exactly 4 clk.
REQ-014 Bytes SHALL be sent LSB first: SYNC 0x80; PID byte {~pid,pid} with pid DATA0=0x3, DATA1=0xB, ACK=0x2, NAK=0xA, STALL=0xE (ACK byte = 0xD2).
REQ-015 NRZI: data 0 toggles the line state, data 1 holds it; encoder starts from J at every packet.
REQ-016 Bit stuffing: after six consecutive 1s, a 0 SHALL be inserted; the ones counter resets on any 0 (sent or stuffed); stuffing applies from SYNC through CRC_HI, never during EOP.
REQ-017 LOAD: get_TX_packet_data SHALL pulse once per payload byte, at least 1 clk before that byte's first bit; exactly the latched count is popped (0 allowed).
REQ-018 CRC16: poly 0x8005 reflected, init 0xFFFF, over payload only; the ones-complement is sent low byte then high byte; zero-length payload sends 0x00,0x00.
REQ-019 EOP: SE0 (0,0) for 2 bit cells, then J for 1 bit cell; then IDLE holds J.
REQ-020 TX_transfer_active SHALL rise with the first SYNC bit and fall after the EOP J cell (ACK: exactly 76 clk high).
REQ-021 Bits on bus SHALL equal 8*(2+N+2) + stuffed bits + 3 for a data packet with N payload bytes.
REQ-022 Payload above 64 SHALL be treated as invalid: TX_error pulse, no transmission.

Reset
REQ-023 While rst is high at a clk edge: FSM to IDLE, dp_out=1, dm_out=0, TX_transfer_active=0, TX_error=0, get_TX_packet_data=0, CRC=0xFFFF, counters 0.
REQ-024 Reset mid-packet SHALL abort immediately with no EOP; the next packet starts cleanly.

Configuration
REQ-025 Macro USB_TX_CRC16_EN: defined -> CRC_LO/CRC_HI generated per REQ-018; undefined -> CRC states and logic absent; EOP follows the last payload byte, and the FIFO supplies any CRC bytes as payload.

Verification
REQ-026 ACK request -> bus NRZI K J K J K J K K | PID 0xD2 | SE0 SE0 J; 76 clk active; no pops.
REQ-027 DATA0, N=0 -> SYNC, PID 0xC3, CRC 0x00 0x00, EOP; 0 pops (CRC_EN defined).
REQ-028 DATA1, N=3 payload 0xFF 0xFF 0xFF -> stuffed 0s after every 6th 1; 3 pops; decoded stream matches with CRC from REQ-018.
REQ-029 TX_packet=7 in IDLE -> TX_error high 1 clk; bus stays J; TX_transfer_active stays 0.
REQ-030 rst asserted during DATA of a 64-byte DATA0 -> next clk bus J, active 0; following NAK is sent correctly.
REQ-031 TX_packet changed during a NAK transfer -> NAK completes unchanged; the new request is accepted only after return to IDLE.

Source files
------------

// File: rtl/usb_tx.sv
// USB full-speed packet transmitter: SYNC/PID/payload/CRC16 with NRZI, bit stuffing and EOP.
// Optional feature macro USB_TX_CRC16_EN: when defined, the CRC16 trailer is generated here.
module usb_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] TX_packet,
    input  logic [7:0] TX_packet_data,
    input  logic [6:0] buffer_occupancy,
    output logic       get_TX_packet_data,
    output logic       dp_out,
    output logic       dm_out,
    output logic       TX_transfer_active,
    output logic       TX_error
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_SYNC    = 4'd1,
        S_PID     = 4'd2,
        S_LOAD    = 4'd3,
        S_DATA    = 4'd4,
`ifdef USB_TX_CRC16_EN
        S_CRC_LO  = 4'd5,
        S_CRC_HI  = 4'd6,
`endif
        S_EOP_SE0 = 4'd7,
        S_EOP_J   = 4'd8
    } state_t;

    state_t      r_state;
    logic [2:0]  r_pkt;
    logic [6:0]  r_pop_left;
    logic [6:0]  r_tx_left;
    logic [7:0]  r_shift;
    logic [7:0]  r_fifo_byte;
    logic [3:0]  r_bit_cnt;
    logic [1:0]  r_cell;
    logic [2:0]  r_ones;
    logic        r_level;
    logic        r_pop;
    logic        r_pop_d;
    logic        r_dp;
    logic        r_dm;
    logic        r_active;
    logic        r_error;
`ifdef USB_TX_CRC16_EN
    logic [15:0] r_crc;

    // Reflected 0x8005 (0xA001), payload bits taken LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++)
            c = (c[0] ^ d[i]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        return c;
    endfunction
`endif

    logic       w_is_data;
    logic       w_req_data;
    logic       w_req_valid;
    logic [3:0] w_pid;
    logic       w_cell_end;
    logic       w_stuff;
    logic       w_byte_end;
    state_t     w_next_state;
    logic [7:0] w_next_byte;
    logic       w_load_payload;
    logic [7:0] w_src;
    logic       w_bit;
    logic       w_new_level;

    assign w_is_data   = (r_pkt == 3'd1) || (r_pkt == 3'd2);
    assign w_req_data  = (TX_packet == 3'd1) || (TX_packet == 3'd2);
    assign w_req_valid = (TX_packet != 3'd0) && (TX_packet <= 3'd5)
                         && !(w_req_data && (buffer_occupancy > 7'd64));
    assign w_cell_end  = (r_cell == 2'd3);
    assign w_stuff     = (r_ones == 3'd6);
    assign w_byte_end  = (r_bit_cnt == 4'd8);
    assign w_src       = w_byte_end ? w_next_byte : r_shift;
    assign w_bit       = !w_stuff && w_src[0];
    // NRZI: a 0 (sent or stuffed) toggles the line, a 1 holds it.
    assign w_new_level = w_bit ? r_level : ~r_level;

    always_comb begin
        case (r_pkt)
            3'd1:    w_pid = 4'h3;
            3'd2:    w_pid = 4'hB;
            3'd3:    w_pid = 4'h2;
            3'd4:    w_pid = 4'hA;
            3'd5:    w_pid = 4'hE;
            default: w_pid = 4'h0;
        endcase
    end

    // Byte that follows the one currently on the wire, and the state that owns it.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_next_state   = S_IDLE;
        w_next_byte    = 8'h00;
        w_load_payload = 1'b0;
        case (r_state)
            S_SYNC: begin
                w_next_state = S_PID;
                w_next_byte  = {~w_pid, w_pid};
            end
            S_PID, S_LOAD, S_DATA: begin
                if (!w_is_data) begin
                    w_next_state = S_EOP_SE0;
                end else if (r_tx_left != 7'd0) begin
                    w_next_state   = S_LOAD;
                    w_next_byte    = r_fifo_byte;
                    w_load_payload = 1'b1;
                end else begin
`ifdef USB_TX_CRC16_EN
                    w_next_state = S_CRC_LO;
                    w_next_byte  = ~r_crc[7:0];
`else
                    w_next_state = S_EOP_SE0;
`endif
                end
            end
`ifdef USB_TX_CRC16_EN
            S_CRC_LO: begin
                w_next_state = S_CRC_HI;
                w_next_byte  = ~r_crc[15:8];
            end
            S_CRC_HI: w_next_state = S_EOP_SE0;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            r_state     <= S_IDLE;
            r_pkt       <= 3'd0;
            r_pop_left  <= 7'd0;
            r_tx_left   <= 7'd0;
            r_shift     <= 8'h00;
            r_fifo_byte <= 8'h00;
            r_bit_cnt   <= 4'd0;
            r_cell      <= 2'd0;
            r_ones      <= 3'd0;
            r_level     <= 1'b1;
            r_pop       <= 1'b0;
            r_pop_d     <= 1'b0;
            r_dp        <= 1'b1;
            r_dm        <= 1'b0;
            r_active    <= 1'b0;
            r_error     <= 1'b0;
`ifdef USB_TX_CRC16_EN
            r_crc       <= 16'hFFFF;
`endif
        end else begin
            r_error <= 1'b0;
            r_pop   <= 1'b0;
            r_pop_d <= r_pop;
            if (r_pop_d)
                r_fifo_byte <= TX_packet_data;
            case (r_state)
                S_IDLE: begin
                    r_level  <= 1'b1;
                    r_dp     <= 1'b1;
                    r_dm     <= 1'b0;
                    r_active <= 1'b0;
                    if (w_req_valid) begin
                        // First SYNC bit (a 0) goes out on this edge: J -> K.
                        r_pkt      <= TX_packet;
                        r_pop_left <= w_req_data ? buffer_occupancy : 7'd0;
                        r_tx_left  <= w_req_data ? buffer_occupancy : 7'd0;
                        r_state    <= S_SYNC;
                        r_level    <= 1'b0;
                        r_dp       <= 1'b0;
                        r_dm       <= 1'b1;
                        r_shift    <= 8'h40;
                        r_bit_cnt  <= 4'd1;
                        r_cell     <= 2'd0;
                        r_ones     <= 3'd0;
                        r_active   <= 1'b1;
`ifdef USB_TX_CRC16_EN
                        r_crc      <= 16'hFFFF;
`endif
                    end else if (TX_packet != 3'd0) begin
                        r_error <= 1'b1;
                    end
                end
                S_EOP_SE0: begin
                    r_cell <= r_cell + 2'd1;
                    if (w_cell_end) begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd1) begin
                            r_state <= S_EOP_J;
                            r_dp    <= 1'b1;
                            r_dm    <= 1'b0;
                        end
                    end
                end
                S_EOP_J: begin
                    r_cell <= r_cell + 2'd1;
                    if (w_cell_end) begin
                        r_state   <= S_IDLE;
                        r_active  <= 1'b0;
                        r_bit_cnt <= 4'd0;
                    end
                end
                default: begin
                    r_cell <= r_cell + 2'd1;
                    if (r_state == S_LOAD) begin
                        // Prefetch the following byte while this one is serialised.
                        r_state <= S_DATA;
                        if (r_pop_left != 7'd0) begin
                            r_pop      <= 1'b1;
                            r_pop_left <= r_pop_left - 7'd1;
                        end
                    end else if (w_cell_end) begin
                        if (!w_stuff && w_byte_end && (w_next_state == S_EOP_SE0)) begin
                            r_state   <= S_EOP_SE0;
                            r_dp      <= 1'b0;
                            r_dm      <= 1'b0;
                            r_bit_cnt <= 4'd0;
                        end else begin
                            r_level <= w_new_level;
                            r_dp    <= w_new_level;
                            r_dm    <= ~w_new_level;
                            r_ones  <= w_bit ? (r_ones + 3'd1) : 3'd0;
                            if (!w_stuff) begin
                                r_shift   <= {1'b0, w_src[7:1]};
                                r_bit_cnt <= w_byte_end ? 4'd1 : (r_bit_cnt + 4'd1);
                                if (w_byte_end) begin
                                    r_state <= w_next_state;
                                    if (w_load_payload) begin
                                        r_tx_left <= r_tx_left - 7'd1;
`ifdef USB_TX_CRC16_EN
                                        r_crc     <= crc16_byte(r_crc, r_fifo_byte);
`endif
                                    end
                                    if ((r_state == S_SYNC) && (r_pop_left != 7'd0)) begin
                                        r_pop      <= 1'b1;
                                        r_pop_left <= r_pop_left - 7'd1;
                                    end
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign get_TX_packet_data = r_pop;
    assign dp_out             = r_dp;
    assign dm_out             = r_dm;
    assign TX_transfer_active = r_active;
    assign TX_error           = r_error;

endmodule

// File: tb/tb_usb_tx.sv
// Scoreboard bench for usb_tx: expected bus samples per clk are queued when a request is driven.
module tb_usb_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] TX_packet = 3'd0;
    logic [7:0] TX_packet_data = 8'h00;
    logic [6:0] buffer_occupancy = 7'd0;
    logic       get_TX_packet_data;
    logic       dp_out;
    logic       dm_out;
    logic       TX_transfer_active;
    logic       TX_error;

    usb_tx dut (
        .clk               (clk),
        .rst               (rst),
        .TX_packet         (TX_packet),
        .TX_packet_data    (TX_packet_data),
        .buffer_occupancy  (buffer_occupancy),
        .get_TX_packet_data(get_TX_packet_data),
        .dp_out            (dp_out),
        .dm_out            (dm_out),
        .TX_transfer_active(TX_transfer_active),
        .TX_error          (TX_error)
    );

    always #10 clk = ~clk;

    // FIFO model: a pop strobe makes the next byte valid for the following cycle.
    logic [7:0] fifo_mem [0:255];
    logic [7:0] fifo_rd   = 8'd0;
    int         pop_total = 0;

    always @(negedge clk) begin
        if (get_TX_packet_data) begin
            TX_packet_data = fifo_mem[fifo_rd];
            fifo_rd        = fifo_rd + 8'd1;
            pop_total      = pop_total + 1;
        end
    end

    int         n_checks = 0;
    int         n_errors = 0;
    logic [1:0] exp_q [$];
    logic       model_level;
    int         model_ones;
    logic [7:0] pl [0:63];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_cell();
        repeat (4) exp_q.push_back({model_level, ~model_level});
    endtask

    task automatic push_bit(input logic b);
        if (!b) model_level = ~model_level;
        push_cell();
        model_ones = b ? model_ones + 1 : 0;
        if (model_ones == 6) begin
            model_level = ~model_level;
            model_ones  = 0;
            push_cell();
        end
    endtask

    task automatic push_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) push_bit(v[i]);
    endtask

    function automatic logic [3:0] pid_of(input logic [2:0] p);
        case (p)
            3'd1:    return 4'h3;
            3'd2:    return 4'hB;
            3'd3:    return 4'h2;
            3'd4:    return 4'hA;
            default: return 4'hE;
        endcase
    endfunction

`ifdef USB_TX_CRC16_EN
    function automatic logic [15:0] crc16_usb(input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int k = 0; k < n; k++)
            for (int i = 0; i < 8; i++) begin
                fb = c[0] ^ pl[k][i];
                c  = {1'b0, c[15:1]};
                if (fb) c = c ^ 16'hA001;
            end
        return c;
    endfunction
`endif

    // Queue the complete expected bus waveform and stage the payload in the FIFO.
    task automatic build(input logic [2:0] pkt, input int n);
        logic [3:0]  pid;
        logic [7:0]  idx;
`ifdef USB_TX_CRC16_EN
        logic [15:0] crc;
`endif
        model_level = 1'b1;
        model_ones  = 0;
        pid         = pid_of(pkt);
        push_byte(8'h80);
        push_byte({~pid, pid});
        if (pkt == 3'd1 || pkt == 3'd2) begin
            for (int k = 0; k < n; k++) begin
                idx           = fifo_rd + 8'(k);
                fifo_mem[idx] = pl[k];
                push_byte(pl[k]);
            end
`ifdef USB_TX_CRC16_EN
            crc = ~crc16_usb(n);
            push_byte(crc[7:0]);
            push_byte(crc[15:8]);
`endif
        end
        repeat (8) exp_q.push_back(2'b00);
        repeat (4) exp_q.push_back(2'b10);
    endtask

    task automatic run_expected(input logic [2:0] req_after, input int max_clk);
        logic [1:0] e;
        int         cnt;
        cnt = 0;
        while (exp_q.size() > 0 && cnt < max_clk) begin
            @(negedge clk);
            if (cnt == 0) TX_packet = req_after;
            e = exp_q.pop_front();
            check($sformatf("bus@%0d", cnt), {TX_transfer_active, dp_out, dm_out}, {1'b1, e});
            cnt++;
        end
    endtask

    task automatic expect_idle(input string tag);
        check(tag, {TX_transfer_active, dp_out, dm_out, TX_error, get_TX_packet_data}, 5'b01000);
    endtask

    task automatic send(input logic [2:0] pkt, input int n, input string tag);
        int p0;
        @(negedge clk);
        p0 = pop_total;
        build(pkt, n);
        TX_packet        = pkt;
        buffer_occupancy = 7'(n);
        run_expected(3'd0, 100000);
        @(negedge clk);
        expect_idle({tag, "_idle"});
        check({tag, "_pops"}, pop_total - p0, n);
    endtask

    task automatic expect_reject(input logic [2:0] pkt, input logic [6:0] occ, input string tag);
        @(negedge clk);
        TX_packet        = pkt;
        buffer_occupancy = occ;
        @(negedge clk);
        TX_packet = 3'd0;
        check({tag, "_pulse"}, {TX_error, TX_transfer_active, dp_out, dm_out}, 4'b1010);
        @(negedge clk);
        check({tag, "_clear"}, {TX_error, TX_transfer_active, dp_out, dm_out}, 4'b0010);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        expect_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        expect_idle("post_reset");

        send(3'd3, 0, "ack");
        send(3'd1, 0, "data0_n0");
        for (int k = 0; k < 3; k++) pl[k] = 8'hFF;
        send(3'd2, 3, "data1_ff");
        for (int k = 0; k < 5; k++) pl[k] = 8'($urandom);
        send(3'd1, 5, "data0_rand");
        for (int k = 0; k < 4; k++) pl[k] = 8'h00;
        send(3'd2, 4, "data1_zero");
        send(3'd5, 0, "stall");

        expect_reject(3'd7, 7'd0, "inv7");
        expect_reject(3'd6, 7'd0, "inv6");
        expect_reject(3'd1, 7'd65, "occ65");

        // Abort a 64-byte DATA0 in the middle of its payload.
        for (int k = 0; k < 64; k++) pl[k] = 8'($urandom);
        @(negedge clk);
        build(3'd1, 64);
        TX_packet        = 3'd1;
        buffer_occupancy = 7'd64;
        run_expected(3'd0, 300);
        rst = 1'b1;
        @(negedge clk);
        expect_idle("abort");
        rst = 1'b0;
        exp_q.delete();
        send(3'd4, 0, "nak_after_abort");

        // A request change during a NAK must wait for the return to IDLE.
        @(negedge clk);
        build(3'd4, 0);
        TX_packet        = 3'd4;
        buffer_occupancy = 7'd0;
        run_expected(3'd1, 100000);
        @(negedge clk);
        expect_idle("nak_hold_idle");
        begin
            int p0;
            p0 = pop_total;
            build(3'd1, 0);
            run_expected(3'd0, 100000);
            @(negedge clk);
            expect_idle("late_data0_idle");
            check("late_data0_pops", pop_total - p0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
